ifid_skid_latch: RTL and testbench

- Pipeline register between instruction fetch and decode; feeds the decode stage and the ID/EX register.
- Holds fetched instruction, PC_Next and fetch error in a 2-entry skid buffer, so fetch can run against a registered ready while decode stalls.
- Handles flush on a taken branch or jump, and load-use stall.
- Stops accepting new instructions after a HALT until a flush.

---
 rtl/ifid_skid_latch.sv | 114 +++++++++++
 tb/tb_ifid_skid_latch.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ifid_skid_latch.sv
// IF/ID pipeline register built as a 2-entry skid buffer so that fetch sees a
// registered ready while decode stalls; supports flush, load-use stall and HALT.
module ifid_skid_latch #(
  parameter int                 WIDTH     = 16,
  parameter logic [WIDTH-1:0]   NOP_INSTR = 16'h0800,
  parameter logic [4:0]         HALT_OPC  = 5'b00000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] IF_Instr,
  input  logic [WIDTH-1:0] IF_PC_Next,
  input  logic             IF_err,
  input  logic             IF_valid,
  output logic             IF_ready,
  input  logic             ID_stall,
  input  logic             ID_flush,
  output logic [WIDTH-1:0] IFID_Instr,
  output logic [WIDTH-1:0] IFID_PC_Next,
  output logic             IFID_err,
  output logic             IFID_valid,
  output logic             IFID_halt_seen
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] p_instr, p_pc, s_instr, s_pc;
  logic             p_err, s_err;
  logic             halt_seen, halt_next;
  logic             put, take;
  logic             load_p_in, load_p_skid, load_s;

  assign IF_ready       = (state != FULL) && !halt_seen;
  assign IFID_valid     = (state != EMPTY);
  assign IFID_Instr     = IFID_valid ? p_instr : NOP_INSTR;
  assign IFID_PC_Next   = p_pc;
  assign IFID_err       = IFID_valid & p_err;
  assign IFID_halt_seen = halt_seen;

  assign put  = IF_valid & IF_ready;
  assign take = IFID_valid & ~ID_stall;

  always_comb begin
    state_next  = state;
    halt_next   = halt_seen;
    load_p_in   = 1'b0;
    load_p_skid = 1'b0;
    load_s      = 1'b0;
    if (ID_flush) begin
      // Flush wins over everything except reset; a same-cycle put is dropped.
      state_next = EMPTY;
      halt_next  = 1'b0;
    end else begin
      if (put && (IF_Instr[WIDTH-1 -: 5] == HALT_OPC))
        halt_next = 1'b1;
      unique case (state)
        EMPTY: begin
          if (put) begin
            state_next = ONE;
            load_p_in  = 1'b1;
          end
        end
        ONE: begin
          if (put && take) begin
            load_p_in = 1'b1;
          end else if (put) begin
            state_next = FULL;
            load_s     = 1'b1;
          end else if (take) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (take) begin
            state_next  = ONE;
            load_p_skid = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= EMPTY;
      halt_seen <= 1'b0;
      p_instr   <= NOP_INSTR;
      p_pc      <= '0;
      p_err     <= 1'b0;
      s_instr   <= NOP_INSTR;
      s_pc      <= '0;
      s_err     <= 1'b0;
    end else begin
      state     <= state_next;
      halt_seen <= halt_next;
      if (load_p_in) begin
        p_instr <= IF_Instr;
        p_pc    <= IF_PC_Next;
        p_err   <= IF_err;
      end else if (load_p_skid) begin
        p_instr <= s_instr;
        p_pc    <= s_pc;
        p_err   <= s_err;
      end
      if (load_s) begin
        s_instr <= IF_Instr;
        s_pc    <= IF_PC_Next;
        s_err   <= IF_err;
      end
    end
  end

endmodule

// File: tb/tb_ifid_skid_latch.sv
// Directed, table-driven bench for ifid_skid_latch: each record gives the
// inputs for one cycle and the outputs expected just after that clock edge.
module tb_ifid_skid_latch;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] IF_Instr, IF_PC_Next;
  logic        IF_err, IF_valid, IF_ready;
  logic        ID_stall, ID_flush;
  logic [15:0] IFID_Instr, IFID_PC_Next;
  logic        IFID_err, IFID_valid, IFID_halt_seen;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic        rst;
    logic        ifv;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        err;
    logic        stall;
    logic        flush;
    logic        e_ready;
    logic        e_valid;
    logic [15:0] e_instr;
    logic [15:0] e_pc;
    logic        e_err;
    logic        e_halt;
  } vec_t;

  vec_t vecs[$];

  ifid_skid_latch dut (
    .clk(clk), .rst(rst),
    .IF_Instr(IF_Instr), .IF_PC_Next(IF_PC_Next), .IF_err(IF_err),
    .IF_valid(IF_valid), .IF_ready(IF_ready),
    .ID_stall(ID_stall), .ID_flush(ID_flush),
    .IFID_Instr(IFID_Instr), .IFID_PC_Next(IFID_PC_Next), .IFID_err(IFID_err),
    .IFID_valid(IFID_valid), .IFID_halt_seen(IFID_halt_seen)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic v, logic [15:0] i, logic [15:0] p,
                              logic e, logic s, logic f, logic er, logic ev,
                              logic [15:0] ei, logic [15:0] ep, logic ee, logic eh);
    vec_t t;
    t.rst = r; t.ifv = v; t.instr = i; t.pc = p; t.err = e; t.stall = s; t.flush = f;
    t.e_ready = er; t.e_valid = ev; t.e_instr = ei; t.e_pc = ep; t.e_err = ee; t.e_halt = eh;
    return t;
  endfunction

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst        = v.rst;
    IF_valid   = v.ifv;
    IF_Instr   = v.instr;
    IF_PC_Next = v.pc;
    IF_err     = v.err;
    ID_stall   = v.stall;
    ID_flush   = v.flush;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    cmp({tag, ".IF_ready"},       {15'd0, IF_ready},       {15'd0, v.e_ready});
    cmp({tag, ".IFID_valid"},     {15'd0, IFID_valid},     {15'd0, v.e_valid});
    cmp({tag, ".IFID_Instr"},     IFID_Instr,              v.e_instr);
    cmp({tag, ".IFID_PC_Next"},   IFID_PC_Next,            v.e_pc);
    cmp({tag, ".IFID_err"},       {15'd0, IFID_err},       {15'd0, v.e_err});
    cmp({tag, ".IFID_halt_seen"}, {15'd0, IFID_halt_seen}, {15'd0, v.e_halt});
  endtask

  initial begin
    int waited;
    vec_t h;

    // Reset, then streaming with no stall.
    vecs.push_back(mk(0,0,16'h0000,16'h0000,0,0,0, 1,0,16'h0800,16'h0000,0,0));
    vecs.push_back(mk(0,0,16'h0000,16'h0000,0,0,0, 1,0,16'h0800,16'h0000,0,0));
    vecs.push_back(mk(1,1,16'h4001,16'h0002,0,0,0, 1,1,16'h4001,16'h0002,0,0));
    vecs.push_back(mk(1,1,16'h4002,16'h0004,0,0,0, 1,1,16'h4002,16'h0004,0,0));
    vecs.push_back(mk(1,1,16'h4003,16'h0006,0,0,0, 1,1,16'h4003,16'h0006,0,0));
    vecs.push_back(mk(1,0,16'h0000,16'h0000,0,0,0, 1,0,16'h0800,16'h0006,0,0));
    // Skid: stall three cycles while the next instruction is presented.
    vecs.push_back(mk(1,1,16'h4001,16'h0002,0,0,0, 1,1,16'h4001,16'h0002,0,0));
    vecs.push_back(mk(1,1,16'h4002,16'h0004,0,1,0, 0,1,16'h4001,16'h0002,0,0));
    vecs.push_back(mk(1,1,16'h4002,16'h0004,0,1,0, 0,1,16'h4001,16'h0002,0,0));
    vecs.push_back(mk(1,1,16'h4002,16'h0004,0,1,0, 0,1,16'h4001,16'h0002,0,0));
    vecs.push_back(mk(1,0,16'h0000,16'h0000,0,0,0, 1,1,16'h4002,16'h0004,0,0));
    vecs.push_back(mk(1,0,16'h0000,16'h0000,0,0,0, 1,0,16'h0800,16'h0004,0,0));
    // Flush while FULL with fetch presenting; stall in EMPTY is ignored.
    vecs.push_back(mk(1,1,16'h4010,16'h0010,0,1,0, 1,1,16'h4010,16'h0010,0,0));
    vecs.push_back(mk(1,1,16'h4011,16'h0012,0,1,0, 0,1,16'h4010,16'h0010,0,0));
    vecs.push_back(mk(1,1,16'h4012,16'h0014,0,1,1, 1,0,16'h0800,16'h0010,0,0));
    vecs.push_back(mk(1,0,16'h0000,16'h0000,0,0,0, 1,0,16'h0800,16'h0010,0,0));
    // Flush in ONE discards a real same-cycle put.
    vecs.push_back(mk(1,1,16'h4020,16'h0020,0,0,0, 1,1,16'h4020,16'h0020,0,0));
    vecs.push_back(mk(1,1,16'h4021,16'h0022,0,0,1, 1,0,16'h0800,16'h0020,0,0));
    vecs.push_back(mk(1,0,16'h0000,16'h0000,0,0,0, 1,0,16'h0800,16'h0020,0,0));
    // HALT blocks further fetch until a flush.
    vecs.push_back(mk(1,1,16'h0000,16'h0024,0,0,0, 0,1,16'h0000,16'h0024,0,1));
    vecs.push_back(mk(1,1,16'h4005,16'h0026,0,1,0, 0,1,16'h0000,16'h0024,0,1));
    vecs.push_back(mk(1,1,16'h4005,16'h0026,0,0,0, 0,0,16'h0800,16'h0024,0,1));
    vecs.push_back(mk(1,1,16'h4005,16'h0026,0,0,0, 0,0,16'h0800,16'h0024,0,1));
    vecs.push_back(mk(1,1,16'h4005,16'h0026,0,0,1, 1,0,16'h0800,16'h0024,0,0));
    // Error passthrough, then reset while FULL.
    vecs.push_back(mk(1,1,16'h4006,16'h0028,1,0,0, 1,1,16'h4006,16'h0028,1,0));
    vecs.push_back(mk(1,0,16'h0000,16'h0000,0,1,0, 1,1,16'h4006,16'h0028,1,0));
    vecs.push_back(mk(1,1,16'h4007,16'h002A,0,1,0, 0,1,16'h4006,16'h0028,1,0));
    vecs.push_back(mk(0,1,16'h4008,16'h002C,0,1,0, 1,0,16'h0800,16'h0000,0,0));
    vecs.push_back(mk(1,0,16'h0000,16'h0000,0,0,0, 1,0,16'h0800,16'h0000,0,0));
    // Error must be masked once the entry is no longer valid.
    vecs.push_back(mk(1,1,16'h4009,16'h002C,1,0,0, 1,1,16'h4009,16'h002C,1,0));
    vecs.push_back(mk(1,0,16'h0000,16'h0000,0,0,0, 1,0,16'h0800,16'h002C,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], $sformatf("vec%0d", i));
    end

    // Hand sequence: fill to FULL, release stall, and bound the wait for ready.
    h = mk(1,1,16'h4031,16'h0030,0,1,0, 1,1,16'h4031,16'h0030,0,0);
    applyStimulus(h); checkOutput(h, "seqA");
    h = mk(1,1,16'h4032,16'h0032,0,1,0, 0,1,16'h4031,16'h0030,0,0);
    applyStimulus(h); checkOutput(h, "seqB");
    IF_valid = 1'b0;
    ID_stall = 1'b0;
    waited   = 0;
    while (!IF_ready && waited < 4) begin
      @(posedge clk);
      #1;
      waited++;
    end
    cmp("seq.ready_wait_cycles", waited[15:0], 16'd1);
    cmp("seq.skid_instr", IFID_Instr, 16'h4032);
    cmp("seq.skid_pc", IFID_PC_Next, 16'h0032);
    h = mk(1,1,16'h4033,16'h0034,0,0,0, 1,1,16'h4033,16'h0034,0,0);
    applyStimulus(h); checkOutput(h, "seqC");
    h = mk(1,0,16'h0000,16'h0000,0,0,0, 1,0,16'h0800,16'h0034,0,0);
    applyStimulus(h); checkOutput(h, "seqD");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
